// File: rtl/gb_bus_pkg.sv
// Shared address map, transfer constants and state/region types for the CPU bus fabric.
package gb_bus_pkg;

  localparam logic [15:0] IO_BASE      = 16'hFF00;
  localparam logic [15:0] HRAM_BASE    = 16'hFF80;
  localparam logic [15:0] IE_ADDR      = 16'hFFFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] ECHO_BASE    = 16'hE000;
  localparam logic [7:0]  ECHO_HI      = 8'hE0;
  localparam logic [7:0]  ECHO_OFS     = 8'h20;

  localparam int unsigned XFER_LEN    = 160;
  localparam int unsigned START_DELAY = 1;
  localparam int unsigned IDX_W       = 8;

  typedef enum logic [1:0] {IDLE, START, XFER} dma_state_t;
  typedef enum logic [1:0] {EXT, IO, HRAM, DMA_REG} region_t;

  // Echo RAM pages fold back onto work RAM; the register keeps the raw value.
  function automatic logic [7:0] mirror_src(input logic [7:0] hi);
    return (hi >= ECHO_HI) ? 8'(hi - ECHO_OFS) : hi;
  endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU port plus ext/io downstream buses around the OAM DMA controller.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata;
  logic        ext_rd;
  logic        ext_wr;
  logic [7:0]  ext_rdata;
  logic [15:0] io_addr;
  logic [7:0]  io_wdata;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  io_rdata;
  logic        dma_active;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr, ext_rdata, io_rdata,
    output cpu_rdata, ext_addr, ext_wdata, ext_rd, ext_wr,
           io_addr, io_wdata, io_rd, io_wr, dma_active
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr, ext_rdata, io_rdata,
    input  cpu_rdata, ext_addr, ext_wdata, ext_rd, ext_wr,
           io_addr, io_wdata, io_rd, io_wr, dma_active
  );
endinterface

// File: rtl/gb_addr_region.sv
// Classifies a CPU address into ext bus, io registers, HRAM or the DMA register.
module gb_addr_region
  import gb_bus_pkg::*;
(
  input  logic [15:0] addr,
  output region_t     region_c
);

  // IE at 0xFFFF is an io register, not HRAM.
  always_comb begin
    region_c = EXT;
    if (addr == DMA_REG_ADDR)                        region_c = DMA_REG;
    else if (addr >= HRAM_BASE && addr != IE_ADDR)   region_c = HRAM;
    else if (addr >= IO_BASE)                        region_c = IO;
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies XFER_LEN bytes from {src_hi,8'h00} into OAM and
// arbitrates CPU access to the ext/io buses while the copy runs.
module oam_dma_ctrl
  import gb_bus_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     t_cycle,
  oam_dma_ctrl_if.master bus
);

  localparam int unsigned DLY_W = 2;

  dma_state_t       state;
  logic [7:0]       src_hi;
  logic [7:0]       latch;
  logic [IDX_W-1:0] idx;
  logic [DLY_W-1:0] dly;
  logic             active_q;

  region_t          rgn;
  logic             m_end;
  logic             reg_wr;
  logic [7:0]       src_pg;
  logic [15:0]      oam_addr;

  logic [15:0]      ext_addr_c, io_addr_c;
  logic [7:0]       ext_wdata_c, io_wdata_c, cpu_rdata_c;
  logic             ext_rd_c, ext_wr_c, io_rd_c, io_wr_c;

  gb_addr_region u_region (
    .addr     (bus.cpu_addr),
    .region_c (rgn)
  );

  assign m_end    = (t_cycle == 2'b11);
  assign reg_wr   = bus.cpu_wr && (rgn == DMA_REG) && m_end;
  assign src_pg   = mirror_src(src_hi);
  assign oam_addr = OAM_BASE + {8'h00, idx};

  // Transfer sequencer; a register write restarts from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      src_hi   <= 8'h00;
      latch    <= 8'h00;
      idx      <= '0;
      dly      <= '0;
      active_q <= 1'b0;
    end else begin
      if (state == XFER && t_cycle == 2'b01) latch <= bus.ext_rdata;
      if (reg_wr) begin
        src_hi   <= bus.cpu_wdata;
        state    <= START;
        idx      <= '0;
        dly      <= '0;
        active_q <= 1'b1;
      end else if (m_end) begin
        unique case (state)
          IDLE: ;
          START: begin
            if (dly == DLY_W'(START_DELAY - 1)) begin
              state <= XFER;
              idx   <= '0;
            end else begin
              dly <= dly + DLY_W'(1);
            end
          end
          XFER: begin
            // Terminal compare precedes the increment, so idx never wraps.
            if (idx == IDX_W'(XFER_LEN - 1)) begin
              state    <= IDLE;
              idx      <= '0;
              active_q <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Bus routing: io space always reaches the CPU, ext space belongs to DMA while active.
  always_comb begin
    ext_addr_c  = 16'h0000;
    ext_wdata_c = 8'h00;
    ext_rd_c    = 1'b0;
    ext_wr_c    = 1'b0;
    io_addr_c   = 16'h0000;
    io_wdata_c  = 8'h00;
    io_rd_c     = 1'b0;
    io_wr_c     = 1'b0;
    cpu_rdata_c = 8'hFF;
    if (rst) begin
      if (rgn != EXT) begin
        io_addr_c   = bus.cpu_addr;
        io_wdata_c  = bus.cpu_wdata;
        io_rd_c     = bus.cpu_rd;
        io_wr_c     = bus.cpu_wr;
        cpu_rdata_c = (rgn == DMA_REG) ? src_hi : bus.io_rdata;
      end else if (!active_q) begin
        ext_addr_c  = bus.cpu_addr;
        ext_wdata_c = bus.cpu_wdata;
        ext_rd_c    = bus.cpu_rd;
        ext_wr_c    = bus.cpu_wr;
        cpu_rdata_c = bus.ext_rdata;
      end
      if (state == XFER) begin
        unique case (t_cycle)
          2'b00, 2'b01: begin
            ext_addr_c = {src_pg, idx};
            ext_rd_c   = 1'b1;
          end
          2'b10: begin
            ext_addr_c  = oam_addr;
            ext_wdata_c = latch;
          end
          2'b11: begin
            ext_addr_c  = oam_addr;
            ext_wdata_c = latch;
            ext_wr_c    = 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ext_addr   = ext_addr_c;
  assign bus.ext_wdata  = ext_wdata_c;
  assign bus.ext_rd     = ext_rd_c;
  assign bus.ext_wr     = ext_wr_c;
  assign bus.io_addr    = io_addr_c;
  assign bus.io_wdata   = io_wdata_c;
  assign bus.io_rd      = io_rd_c;
  assign bus.io_wr      = io_wr_c;
  assign bus.cpu_rdata  = cpu_rdata_c;
  assign bus.dma_active = active_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: ext memory model, write log and per-M-cycle activity record
// compared against byte copies computed directly from the source page.
module tb_oam_dma_ctrl;
  import gb_bus_pkg::*;

  localparam int ACT_N = 8192;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] t_cycle = 2'b00;

  oam_dma_ctrl_if bus ();

  oam_dma_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .t_cycle (t_cycle),
    .bus     (bus)
  );

  logic [7:0]  mem [0:65535];
  logic [23:0] wlog [$];
  int          wlog_m [$];
  logic [23:0] exp_q [$];
  bit          act [0:ACT_N-1];
  int          mcyc = 0;
  int          last_wr_m = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) t_cycle <= t_cycle + 2'd1;

  always_comb bus.ext_rdata = mem[bus.ext_addr];
  always_comb bus.io_rdata  = bus.io_addr[7:0] ^ 8'h5A;

  // M-cycle counter, activity record and log of every ext write.
  always @(posedge clk) begin
    if (t_cycle == 2'd3) begin
      mcyc <= mcyc + 1;
      if (mcyc < ACT_N) act[mcyc] <= bus.dma_active;
      if (bus.cpu_wr && bus.cpu_addr == 16'hFF46) last_wr_m <= mcyc;
    end
    if (bus.ext_wr) begin
      wlog.push_back({bus.ext_addr, bus.ext_wdata});
      wlog_m.push_back(mcyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [7:0] d, output logic [7:0] q);
    @(negedge clk);
    while (t_cycle != 2'd0) @(negedge clk);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    @(negedge clk);
    @(negedge clk);
    q = bus.cpu_rdata;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  // Returns at the last T-cycle of M-cycle m-1, so the next cpu_op lands in M-cycle m.
  task automatic wait_m(input int m);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(t_cycle == 2'd3 && mcyc >= m - 1) && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200000) check("wait_bound", 1, 0);
  endtask

  task automatic push_exp(input logic [7:0] src, input int n);
    logic [7:0] pg;
    pg = (src >= 8'hE0) ? src - 8'h20 : src;
    for (int i = 0; i < n; i++)
      exp_q.push_back({16'hFE00 + 16'(i), mem[{pg, 8'(i)}]});
  endtask

  task automatic check_log(input string tag, input int base);
    check({tag, "_count"}, wlog.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++)
      check(tag, wlog[base + i], exp_q[i]);
    exp_q.delete();
  endtask

  function automatic int span(input int w);
    int n;
    n = 0;
    while (w + 1 + n < ACT_N && act[w + 1 + n]) n++;
    return n;
  endfunction

  function automatic int wr_at(input int k, input int w);
    return (k < wlog_m.size()) ? wlog_m[k] - w : -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q, src;
    logic [15:0] a;
    int w, w2, base;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      mem[16'hC100 + i] = 8'(i);
      mem[16'hE200 + i] = ~mem[16'hC200 + i];
    end

    bus.cpu_addr = 16'hC000; bus.cpu_wdata = 8'h00;
    bus.cpu_rd = 1'b1;       bus.cpu_wr = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_ext_rd", bus.ext_rd, 0);
    check("rst_ext_wr", bus.ext_wr, 0);
    check("rst_io_rd", bus.io_rd, 0);
    check("rst_ext_addr", bus.ext_addr, 0);
    check("rst_dma_active", bus.dma_active, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 8'hFF);
    rst = 1'b1;
    bus.cpu_rd = 1'b0;

    cpu_op(1, 0, 16'hC000, 8'h00, q);
    check("idle_ext_read", q, mem[16'hC000]);
    cpu_op(1, 0, 16'hFF10, 8'h00, q);
    check("idle_io_read", q, 8'h10 ^ 8'h5A);

    // Basic copy from 0xC100 with CPU lockout probes in the middle.
    base = wlog.size();
    push_exp(8'hC1, 160);
    cpu_op(0, 1, 16'hFF46, 8'hC1, q);
    w = last_wr_m;
    wait_m(w + 10);
    cpu_op(1, 0, 16'hC000, 8'h00, q); check("dma_ext_read", q, 8'hFF);
    cpu_op(0, 1, 16'hC000, 8'h77, q);
    cpu_op(1, 0, 16'hFF85, 8'h00, q); check("dma_hram_read", q, 8'h85 ^ 8'h5A);
    cpu_op(1, 0, 16'hFF46, 8'h00, q); check("dma_reg_read", q, 8'hC1);
    wait_m(w + 170);
    check("c1_first_wr", wr_at(base, w), 2);
    check("c1_last_wr", wr_at(base + 159, w), 161);
    check("c1_span", span(w), 161);
    check_log("c1_log", base);

    // Echo page source.
    base = wlog.size();
    push_exp(8'hE2, 160);
    cpu_op(0, 1, 16'hFF46, 8'hE2, q);
    w = last_wr_m;
    wait_m(w + 170);
    cpu_op(1, 0, 16'hFF46, 8'h00, q); check("e2_reg_read", q, 8'hE2);
    check("e2_span", span(w), 161);
    check_log("e2_log", base);

    // Restart at idx 50.
    base = wlog.size();
    push_exp(8'hC5, 51);
    push_exp(8'hD0, 160);
    cpu_op(0, 1, 16'hFF46, 8'hC5, q);
    w = last_wr_m;
    wait_m(w + 52);
    cpu_op(0, 1, 16'hFF46, 8'hD0, q);
    w2 = last_wr_m;
    check("restart_mcyc", w2 - w, 52);
    wait_m(w2 + 170);
    check("restart_byte50", wr_at(base + 50, w2), 0);
    check("restart_first_wr", wr_at(base + 51, w2), 2);
    check("restart_span", span(w2), 161);
    check_log("restart_log", base);

    // Reset at idx 80.
    base = wlog.size();
    push_exp(8'hC3, 80);
    cpu_op(0, 1, 16'hFF46, 8'hC3, q);
    w = last_wr_m;
    wait_m(w + 82);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ext_wr", bus.ext_wr, 0);
    check("abort_dma_active", bus.dma_active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_m(w + 90);
    check("abort_active_after", bus.dma_active, 0);
    check_log("abort_log", base);

    base = wlog.size();
    push_exp(8'hC4, 160);
    cpu_op(0, 1, 16'hFF46, 8'hC4, q);
    w = last_wr_m;
    wait_m(w + 170);
    check("post_abort_first_wr", wr_at(base, w), 2);
    check("post_abort_span", span(w), 161);
    check_log("post_abort_log", base);

    // Random source pages with random CPU probes during the copy.
    repeat (3) begin
      src  = 8'($urandom_range(8'h80, 8'hFD));
      base = wlog.size();
      push_exp(src, 160);
      cpu_op(0, 1, 16'hFF46, src, q);
      w = last_wr_m;
      wait_m(w + 3);
      repeat (6) begin
        if ($urandom_range(0, 1) == 0) begin
          a = 16'($urandom_range(0, 16'hFEFF));
          cpu_op(1, 0, a, 8'h00, q);
          check("rnd_ext_read", q, 8'hFF);
        end else begin
          a = {8'hFF, 8'($urandom)};
          cpu_op(1, 0, a, 8'h00, q);
          check("rnd_io_read", q, (a == 16'hFF46) ? src : (a[7:0] ^ 8'h5A));
        end
      end
      wait_m(w + 170);
      check("rnd_span", span(w), 161);
      check_log("rnd_log", base);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
